masked_and_sched: RTL and testbench

Scheduler that shares one two-share masked AND gadget (`ANDos`, D = 2) between `N_REQ` requesters. It arbitrates round-robin, latches the winner's shared operands and draws fresh mask randomness from an internal LFSR. It drives the gadget's enable, waits for its done, and returns the masked product to the winner. It sits between the masked-datapath clients and the single gadget instance.

---
 rtl/masked_pkg.sv | 20 ++
 rtl/mask_lfsr.sv | 29 ++
 rtl/masked_and_sched.sv | 180 ++++++++++++++++++
 tb/tb_masked_and_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_pkg.sv
// Shared types and constants for the masked AND gadget scheduler and its mask LFSR.
// The LFSR shifts right; the tap mask selects bits 0,2,3,5 (x^16 + x^14 + x^13 + x^11 + 1).
package masked_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_CLEAR = 2'd3
    } sched_state_t;

    // Fresh random bits needed by a D-share ISW AND gadget.
    function automatic int rand_w(input int d);
        return d * (d - 1) / 2;
    endfunction

endpackage

// File: rtl/mask_lfsr.sv
// 16-bit Fibonacci LFSR supplying mask randomness; advances one step per i_step.
// The low OUT_W bits of the current state are presented combinationally.
module mask_lfsr
    import masked_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    output logic [OUT_W-1:0] o_bits
);

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb   = ^(r_state & LFSR_TAPS);
    assign o_bits = r_state[OUT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= {w_fb, r_state[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/masked_and_sched.sv
// Round-robin scheduler sharing one 2-share masked AND gadget; grant 1 cycle after req, response 4 cycles after grant.
// Requests wait while an operation is in flight; MASKED_AND_CLEAR_EN adds a one-cycle operand-zeroing CLEAR state.
module masked_and_sched
    import masked_pkg::*;
#(
    parameter int          D         = 2,
    parameter int          N_REQ     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 15,
    localparam int         RAND_W    = rand_w(D)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ*D-1:0]   i_req_a,
    input  logic [N_REQ*D-1:0]   i_req_b,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [D-1:0]         o_rsp_data,
    output logic                 o_rsp_err,
    output logic [D-1:0]         o_and_ina,
    output logic [D-1:0]         o_and_inb,
    output logic [RAND_W-1:0]    o_and_rin,
    output logic                 o_and_enable,
    input  logic                 i_and_done,
    input  logic [D-1:0]         i_and_out
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [D-1:0]       r_a;
    logic [D-1:0]       r_b;
    logic [RAND_W-1:0]  r_rin;
    logic [CNT_W-1:0]   r_to_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [D-1:0]       r_rsp_data;
    logic               r_rsp_err;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_idx;
    logic [D-1:0]       w_win_a;
    logic [D-1:0]       w_win_b;
    logic [N_REQ-1:0]   w_win_oh;
    logic [N_REQ-1:0]   w_own_oh;
    logic [RAND_W-1:0]  w_lfsr_bits;
    logic               w_step;
    logic               w_done_ok;
    logic               w_to_hit;
    logic               w_clr;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_a  = '0;
        w_win_b  = '0;
        w_win_oh = '0;
        w_own_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_win_a     = i_req_a[i*D +: D];
                w_win_b     = i_req_b[i*D +: D];
                w_win_oh[i] = 1'b1;
            end
            if (r_rr_ptr == PTR_W'(i)) begin
                w_own_oh[i] = 1'b1;
            end
        end
    end

    assign w_step = (r_state == S_IDLE) && w_found;

    mask_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (RAND_W)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_step (w_step),
        .o_bits (w_lfsr_bits)
    );

    // A zero count marks the first BUSY cycle, where and_done is still left over from the previous operation.
    assign w_done_ok = (r_state == S_BUSY) && i_and_done && (r_to_cnt != '0);
    assign w_to_hit  = (r_state == S_BUSY) && !w_done_ok && (r_to_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done_ok || w_to_hit) w_state_nxt = S_RESP;
`ifdef MASKED_AND_CLEAR_EN
            S_RESP:  w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_IDLE;
`else
            S_RESP:  w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= PTR_W'(N_REQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_rin       <= '0;
            r_to_cnt    <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_win_oh;
                        r_a      <= w_win_a;
                        r_b      <= w_win_b;
                        r_rin    <= w_lfsr_bits;
                        r_rr_ptr <= w_win;
                        r_to_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_done_ok) begin
                        r_rsp_data  <= i_and_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_own_oh;
                    end else if (w_to_hit) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_own_oh;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Zeroing the gadget inputs between operations keeps shares of consecutive operands from meeting in glitches.
`ifdef MASKED_AND_CLEAR_EN
    assign w_clr = (r_state == S_CLEAR);
`else
    assign w_clr = 1'b0;
`endif

    assign o_and_ina    = w_clr ? '0 : r_a;
    assign o_and_inb    = w_clr ? '0 : r_b;
    assign o_and_rin    = w_clr ? '0 : r_rin;
    assign o_and_enable = (r_state == S_BUSY);
    assign o_gnt        = r_gnt;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_masked_and_sched.sv
// Scoreboard bench for masked_and_sched with a behavioural ISW gadget (normal, never-done and stale-done modes).
module tb_masked_and_sched;

    localparam int D = 2;
    localparam int N = 4;
`ifdef MASKED_AND_CLEAR_EN
    localparam int GAP = 7;
`else
    localparam int GAP = 6;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*D-1:0] req_a;
    logic [N*D-1:0] req_b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [D-1:0]   rsp_data;
    logic           rsp_err;
    logic [D-1:0]   and_ina;
    logic [D-1:0]   and_inb;
    logic [0:0]     and_rin;
    logic           and_enable;
    logic           and_done;
    logic [D-1:0]   and_out;

    always #5 clk = ~clk;

    masked_and_sched dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_gnt        (gnt),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err),
        .o_and_ina    (and_ina),
        .o_and_inb    (and_inb),
        .o_and_rin    (and_rin),
        .o_and_enable (and_enable),
        .i_and_done   (and_done),
        .i_and_out    (and_out)
    );

    int cyc  = 0;
    int ecnt = 0;
    int gmode;   // 0 normal, 1 never done, 2 done also high in BUSY cycle 1

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ecnt <= and_enable ? ecnt + 1 : 0;

    assign and_done = (gmode == 1) ? 1'b0 :
                      (gmode == 2) ? (and_enable && (ecnt == 3 || ecnt == 0)) :
                                     (and_enable && ecnt == 3);
    assign and_out[0] = (and_ina[0] & and_inb[0]) ^ and_rin[0];
    assign and_out[1] = (and_ina[1] & and_inb[1]) ^ (and_rin[0] ^ (and_ina[0] & and_inb[1])) ^ (and_ina[1] & and_inb[0]);

    typedef struct { int idx; logic [1:0] a; logic [1:0] b; logic rin; int lat; int gap; } gexp_t;
    typedef struct { int idx; logic [1:0] dat; logic err; int lat; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int req_cyc  = 0;
    int last_gnt = 0;
    int hold_at  = -1;
    int idle_at  = -1;
    logic [1:0] last_a, last_b;
    logic       last_rin;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        gexp_t g;
        rexp_t r;
        if (gnt != '0) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", int'(gnt), 0);
            end else begin
                g = gq.pop_front();
                chk("gnt_onehot", int'(gnt), 1 << g.idx);
                chk("gnt_and_ina", int'(and_ina), int'(g.a));
                chk("gnt_and_inb", int'(and_inb), int'(g.b));
                chk("gnt_and_rin", int'(and_rin), int'(g.rin));
                chk("gnt_and_enable", int'(and_enable), 1);
                if (g.lat >= 0) chk("gnt_latency", cyc - req_cyc, g.lat);
                if (g.gap >= 0) chk("gnt_spacing", cyc - last_gnt, g.gap);
            end
            last_gnt = cyc;
            last_a   = and_ina;
            last_b   = and_inb;
            last_rin = and_rin[0];
        end
        if (rsp_valid != '0) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", int'(rsp_valid), 0);
            end else begin
                r = rq.pop_front();
                chk("rsp_onehot", int'(rsp_valid), 1 << r.idx);
                chk("rsp_data", int'(rsp_data), int'(r.dat));
                chk("rsp_unmasked", int'(^rsp_data), int'(^r.dat));
                chk("rsp_err", int'(rsp_err), int'(r.err));
                chk("rsp_latency", cyc - last_gnt, r.lat);
                chk("rsp_enable_low", int'(and_enable), 0);
                hold_at = cyc + 1;
                idle_at = cyc + 2;
            end
        end
        if (cyc == hold_at) begin
`ifdef MASKED_AND_CLEAR_EN
            chk("clear_ina", int'(and_ina), 0);
            chk("clear_inb", int'(and_inb), 0);
            chk("clear_rin", int'(and_rin), 0);
`else
            chk("hold_ina", int'(and_ina), int'(last_a));
            chk("hold_inb", int'(and_inb), int'(last_b));
            chk("hold_rin", int'(and_rin), int'(last_rin));
`endif
        end
`ifdef MASKED_AND_CLEAR_EN
        if (cyc == idle_at) chk("clear_one_cycle", int'(and_ina), int'(last_a));
`endif
    endtask

    task automatic issue(input logic [N-1:0] mask, input logic [N*D-1:0] a, input logic [N*D-1:0] b);
        @(posedge clk); #1;
        req_a   = a;
        req_b   = b;
        req     = mask;
        req_cyc = cyc;
        for (int t = 0; t < 200 && req != '0; t++) begin
            @(posedge clk); #1;
            req = req & ~gnt;
        end
        if (req != '0) begin
            chk("grant_wait_expired", int'(req), 0);
            req = '0;
        end
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && (gq.size() != 0 || rq.size() != 0); t++) @(posedge clk);
        if (gq.size() != 0 || rq.size() != 0) begin
            chk("drain_expired", gq.size() + rq.size(), 0);
            gq.delete();
            rq.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        gmode = 0;
        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_and_ina", int'(and_ina), 0);
        chk("rst_and_inb", int'(and_inb), 0);
        chk("rst_and_rin", int'(and_rin), 0);
        chk("rst_and_enable", int'(and_enable), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single op: a=1, b=0 unmasked, first mask bit from the seed is 1.
        gq.push_back('{0, 2'b10, 2'b11, 1'b1, 1, -1});
        rq.push_back('{0, 2'b11, 1'b0, 4});
        issue(4'b0001, 8'b00_00_00_10, 8'b00_00_00_11);
        drain(60);

        // All four requesters held: order 0,1,2,3, mask bits 1,0,0,0.
        do_reset();
        gq.push_back('{0, 2'b01, 2'b10, 1'b1, 1, -1});
        gq.push_back('{1, 2'b11, 2'b01, 1'b0, -1, GAP});
        gq.push_back('{2, 2'b10, 2'b01, 1'b0, -1, GAP});
        gq.push_back('{3, 2'b11, 2'b11, 1'b0, -1, GAP});
        rq.push_back('{0, 2'b01, 1'b0, 4});
        rq.push_back('{1, 2'b11, 1'b0, 4});
        rq.push_back('{2, 2'b10, 1'b0, 4});
        rq.push_back('{3, 2'b11, 1'b0, 4});
        issue(4'b1111, 8'b11_10_11_01, 8'b11_01_01_10);
        drain(100);

        // Gadget never finishes: abort after 15 BUSY cycles.
        do_reset();
        gmode = 1;
        gq.push_back('{2, 2'b11, 2'b11, 1'b1, 1, -1});
        rq.push_back('{2, 2'b00, 1'b1, 15});
        issue(4'b0100, 8'b00_11_00_00, 8'b00_11_00_00);
        drain(80);

        // and_done high in BUSY cycle 1 must be ignored.
        do_reset();
        gmode = 2;
        gq.push_back('{1, 2'b01, 2'b01, 1'b1, 1, -1});
        gq.push_back('{3, 2'b00, 2'b11, 1'b0, -1, GAP});
        rq.push_back('{1, 2'b10, 1'b0, 4});
        rq.push_back('{3, 2'b00, 1'b0, 4});
        issue(4'b1010, 8'b00_00_01_00, 8'b11_00_01_00);
        drain(80);
        gmode = 0;

        // Reset in BUSY cycle 2 aborts silently and reseeds the LFSR.
        do_reset();
        gq.push_back('{0, 2'b11, 2'b10, 1'b1, 1, -1});
        issue(4'b0001, 8'b00_00_00_11, 8'b00_00_00_10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_enable", int'(and_enable), 0);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_and_ina", int'(and_ina), 0);
        repeat (20) @(posedge clk);
        gq.push_back('{0, 2'b11, 2'b10, 1'b1, 1, -1});
        rq.push_back('{0, 2'b11, 1'b0, 4});
        issue(4'b0001, 8'b00_00_00_11, 8'b00_00_00_10);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
